// File: rtl/read_polyq_stream.sv
// Streams P coefficients from a 1-cycle-latency RAM into a 4-deep valid/ready FIFO.
// Optional READ_POLYQ_RANGE_CHECK_EN adds a sticky coefficient >= Q flag.
module read_polyq_stream #(
  parameter int P  = 757,
  parameter int Q  = 4591,
  parameter int DW = 13,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_address_o,
  output logic          mem_read_enable,
  input  logic [DW-1:0] mem_data_i,
  output logic [DW-1:0] coef_o,
  output logic          coef_valid,
  input  logic          coef_ready,
  output logic          coef_last,
  output logic          range_err
);

  localparam int CW = $clog2(P + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  if (P < 1 || P > 2 ** AW || Q < 1 || Q >= 2 ** DW) begin : g_bad_param
    $error("read_polyq_stream: parameter out of range");
  end

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [AW-1:0] base;
  logic [CW-1:0] issued;
  logic [CW-1:0] sent;
  logic          cap_pend;
  logic [DW-1:0] fifo [4];
  logic [1:0]    wp;
  logic [1:0]    rp;
  logic [2:0]    occ;
  logic [2:0]    inflight;
  logic          accept;
  logic          issue;
  logic          push;
  logic          pop;
  logic          last_pop;

  assign accept   = start && (state == S_IDLE);
  assign inflight = {2'b0, mem_read_enable} + {2'b0, cap_pend};
  // Reserve a FIFO slot for every read still in the RAM pipe.
  assign issue    = (state == S_READ) && (issued < CW'(P)) &&
                    ((occ + inflight) < 3'd4);
  assign push     = cap_pend;
  assign pop      = coef_valid && coef_ready;
  assign last_pop = pop && (sent == CW'(P - 1));

  assign coef_valid = (occ != 3'd0);
  assign coef_o     = coef_valid ? fifo[rp] : '0;
  assign coef_last  = coef_valid && (sent == CW'(P - 1));
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (accept) state_nx = S_READ;
      end
      S_READ: begin
        if (issued == CW'(P)) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        // Leave on the final handshake so done follows it directly.
        if (last_pop || sent == CW'(P)) state_nx = S_DONE;
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      base            <= '0;
      issued          <= '0;
      sent            <= '0;
      mem_address_o   <= '0;
      mem_read_enable <= 1'b0;
      cap_pend        <= 1'b0;
      wp              <= '0;
      rp              <= '0;
      occ             <= '0;
    end else begin
      state           <= state_nx;
      mem_read_enable <= issue;
      cap_pend        <= mem_read_enable;
      occ             <= occ + {2'b0, push} - {2'b0, pop};
      if (push) wp <= wp + 2'd1;
      if (pop)  rp <= rp + 2'd1;
      if (accept) begin
        base   <= base_addr;
        issued <= '0;
        sent   <= '0;
      end else begin
        if (issue) begin
          mem_address_o <= base + AW'(issued);
          issued        <= issued + CW'(1);
        end
        if (pop) sent <= sent + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) fifo[i] <= '0;
    end else if (push) begin
      fifo[wp] <= mem_data_i;
    end
  end

`ifdef READ_POLYQ_RANGE_CHECK_EN
  localparam logic [DW-1:0] QV = DW'(Q);

  logic range_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      range_q <= 1'b0;
    end else if (accept) begin
      range_q <= 1'b0;
    end else if (push && mem_data_i >= QV) begin
      range_q <= 1'b1;
    end
  end

  assign range_err = range_q;
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_read_polyq_stream.sv
// Scoreboard bench for read_polyq_stream: stimulus queues expected
// coefficients, a negedge monitor pops and compares on each handshake.
module tb_read_polyq_stream;
  localparam int P  = 757;
  localparam int DW = 13;
  localparam int AW = 11;
`ifdef READ_POLYQ_RANGE_CHECK_EN
  localparam int RC = 1;
`else
  localparam int RC = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_address_o;
  logic          mem_read_enable;
  logic [DW-1:0] mem_data_i = '0;
  logic [DW-1:0] coef_o;
  logic          coef_valid;
  logic          coef_ready = 1'b1;
  logic          coef_last;
  logic          range_err;

  read_polyq_stream dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .mem_address_o(mem_address_o),
    .mem_read_enable(mem_read_enable), .mem_data_i(mem_data_i),
    .coef_o(coef_o), .coef_valid(coef_valid), .coef_ready(coef_ready),
    .coef_last(coef_last), .range_err(range_err)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [2048];
  always @(posedge clk)
    if (mem_read_enable) mem_data_i <= ram[mem_address_o];

  int vecs = 0;
  int errs = 0;
  int dones = 0;
  int rd_cnt = 0;
  int pop_cnt = 0;
  logic [DW:0] sb [$];
  logic [DW:0] e;
  logic [DW:0] held;
  logic        stall_p = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stall_p = 1'b0;
      rd_cnt  = 0;
      pop_cnt = 0;
    end else begin
      if (done) dones++;
      if (mem_read_enable) rd_cnt++;
      if (busy) chk("outstanding_le4", int'(rd_cnt - pop_cnt <= 4), 1);
      if (stall_p)
        chk("stall_hold", int'({coef_valid, coef_last, coef_o}),
            int'({1'b1, held}));
      if (coef_valid && coef_ready) begin
        pop_cnt++;
        if (sb.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL extra_coef: got %0d expected none", coef_o);
        end else begin
          e = sb.pop_front();
          chk("coef", int'(coef_o), int'(e[DW-1:0]));
          chk("last", int'(coef_last), int'(e[DW]));
        end
      end
      stall_p = coef_valid && !coef_ready;
      held    = {coef_last, coef_o};
    end
  end

  task automatic idle_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_rden"}, int'(mem_read_enable), 0);
    chk({tag, "_addr"}, int'(mem_address_o), 0);
    chk({tag, "_valid"}, int'(coef_valid), 0);
    chk({tag, "_last"}, int'(coef_last), 0);
    chk({tag, "_coef"}, int'(coef_o), 0);
    chk({tag, "_rerr"}, int'(range_err), 0);
  endtask

  task automatic go(input logic [AW-1:0] b);
    logic [AW-1:0] a;
    for (int i = 0; i < P; i++) begin
      a = b + AW'(i);
      sb.push_back({(i == P - 1), ram[a]});
    end
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: ready=1; mode 1: backpressure; mode 2: restart attempts
  task automatic run(input logic [AW-1:0] b, input int mode, output int nd);
    logic [AW-1:0] a8;
    a8 = b + AW'(8);
    go(b);
    nd = -1;
    for (int n = 1; n <= 5000; n++) begin
      @(posedge clk); #1;
      if (mode == 1) coef_ready = (n < 40) ? (n % 2 == 1) : (n >= 50);
      if (mode == 2) start = (n == 20);
      if (mode == 2 && n == 20) base_addr = 11'd500;
      if (mode == 0) begin
        if (n == 1) begin
          chk("lat_rden", int'(mem_read_enable), 1);
          chk("lat_addr", int'(mem_address_o), int'(b));
        end
        if (n == 2) chk("lat_valid_c2", int'(coef_valid), 0);
        if (n == 3) chk("lat_valid_c3", int'(coef_valid), 1);
        if (n == 9) chk("addr_c9", int'(mem_address_o), int'(a8));
      end
      if (done) begin
        nd = n;
        if (mode == 2) start = 1'b1;
        break;
      end
    end
    if (nd < 0) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
    start = 1'b0;
    coef_ready = 1'b1;
  endtask

  int nd;
  int d0;

  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = DW'(i);
    repeat (3) @(posedge clk);
    #1;
    idle_outputs("reset");
    rst = 1'b0;

    // full stream from base 0
    d0 = dones;
    run(11'd0, 0, nd);
    chk("t1_done_cycle", nd, P + 3);
    chk("t1_sb_empty", sb.size(), 0);
    chk("t1_done_count", dones - d0, 1);

    // address wrap past 2047
    run(11'd2040, 0, nd);
    chk("t2_done_cycle", nd, P + 3);
    chk("t2_sb_empty", sb.size(), 0);

    // backpressure
    run(11'd100, 1, nd);
    chk("t3_sb_empty", sb.size(), 0);

    // start while busy and in DONE cycle is ignored
    d0 = dones;
    run(11'd0, 2, nd);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_done_count", dones - d0, 1);
    chk("t4_busy", int'(busy), 0);
    chk("t4_rden", int'(mem_read_enable), 0);
    chk("t4_valid", int'(coef_valid), 0);
    chk("t4_sb_empty", sb.size(), 0);

    // reset at coefficient 300
    d0 = dones;
    go(11'd0);
    repeat (303) @(posedge clk);
    #1;
    chk("t5_head_300", int'(coef_o), 300);
    rst = 1'b1;
    sb.delete();
    #1;
    idle_outputs("t5_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_no_done", dones - d0, 0);
    run(11'd0, 0, nd);
    chk("t5_done_cycle", nd, P + 3);
    chk("t5_sb_empty", sb.size(), 0);

    // out-of-range coefficient
    ram[5] = 13'd4591;
    run(11'd0, 0, nd);
    chk("t6_range_err", int'(range_err), RC);
    repeat (4) @(posedge clk);
    #1;
    chk("t6_range_held", int'(range_err), RC);
    ram[5] = 13'd5;
    run(11'd0, 0, nd);
    chk("t6_range_clr", int'(range_err), 0);
    chk("t6_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
